sst16: RTL and testbench

Direct-sequence spread-spectrum transmitter: the generating counterpart of the 16-bit correlator channel. On each sample strobe it advances a carrier DDS and a chip DDS. It steps a programmable Galois-style PRN generator on chip boundaries and emits a 16-bit signed DAC sample equal to the carrier sine multiplied by the current ±1 chip. It sits on the same 32-bit register bus as the receiver channels and drives the loopback/DAC path. It uses the shared combinational `sine` quarter-wave table (13-bit address in, 16-bit out).

---
 rtl/sst16.sv | 219 +++++++++++++++++++++
 tb/tb_sst16.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sst16.sv
`default_nettype none
// ============================================================================
// sst16 : DSSS transmitter - carrier/chip DDS, Galois PRN, chip-modulated DAC
// Revision: 1.0
// ============================================================================

module sine (
  input  logic [12:0] addr,
  output logic [15:0] data
);
  logic [14:0] span;
  logic [27:0] prod;

  // Quarter-wave shape a*(2^14 - a) / 2^11: 0 at address 0, 0x7fff at 0x1fff.
  always_comb begin
    span = 15'd16384 - {2'b00, addr};
    prod = 28'(addr) * 28'(span);
    data = 16'(prod >> 11);
  end
endmodule

module sst16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  input  logic        tick,
  output logic [15:0] DAC,
  output logic        pushDAC,
  output logic        epoch
);
  localparam logic [15:0] ADDR_CTRL       = 16'h0900;
  localparam logic [15:0] ADDR_CAR_FREQ   = 16'h0904;
  localparam logic [15:0] ADDR_CAR_PHASE  = 16'h0908;
  localparam logic [15:0] ADDR_CHIP_FREQ  = 16'h090c;
  localparam logic [15:0] ADDR_CHIP_PHASE = 16'h0910;
  localparam logic [15:0] ADDR_PRN        = 16'h0914;
  localparam logic [15:0] ADDR_SAMPLES    = 16'h0918;
  localparam logic [15:0] ADDR_EPOCHS     = 16'h091c;
  localparam logic [15:0] ADDR_STATUS     = 16'h0920;

  logic        run_q, run_d;
  logic [31:0] car_freq_q, car_freq_d;
  logic [31:0] car_phase_q, car_phase_d;
  logic [31:0] chip_freq_q, chip_freq_d;
  logic [31:0] chip_phase_q, chip_phase_d;
  logic [31:0] prn_q, prn_d;
  logic [31:0] sample_count_q, sample_count_d;
  logic [31:0] epoch_count_q, epoch_count_d;
  logic        epoch_seen_q, epoch_seen_d;
  logic        status_rd_q, status_rd_d;
  logic        s1_valid_q, s1_valid_d;
  logic [12:0] s1_addr_q, s1_addr_d;
  logic        s1_neg_q, s1_neg_d;
  logic [15:0] dac_q, dac_d;
  logic        push_q, push_d;
  logic        epoch_q, epoch_d;

  logic [15:0] reg_addr;
  logic        unused_addr_hi;
  logic        accept;
  logic [31:0] car_sum, chip_sum;
  logic        chip_step;
  logic [3:0]  hob;
  logic [13:0] poly, state;
  logic [15:0] state_ext;
  logic        chip_bit;
  logic [13:0] cleared, shifted, lfsr_next;
  logic        status_hit;
  logic [15:0] tbl, sample;

  assign reg_addr       = addr[15:0];
  assign unused_addr_hi = ^addr[31:16];

  sine u_sine (
    .addr (s1_addr_q),
    .data (tbl)
  );

  always_comb begin
    hob       = prn_q[31:28];
    poly      = prn_q[27:14];
    state     = prn_q[13:0];
    state_ext = {2'b00, state};
    // hob values beyond the 14-bit state read as a zero chip
    chip_bit  = state_ext[hob];
    cleared   = state & ~14'(16'd1 << hob);
    shifted   = cleared << 1;
    lfsr_next = chip_bit ? (shifted ^ poly) : shifted;

    accept    = tick & run_q;
    car_sum   = car_phase_q + car_freq_q;
    chip_sum  = chip_phase_q + chip_freq_q;
    chip_step = accept & ~chip_phase_q[31] & chip_sum[31];

    if (s1_neg_q) sample = (tbl == 16'h8000) ? 16'h7fff : (~tbl + 16'd1);
    else          sample = tbl;
  end

  always_comb begin
    run_d          = run_q;
    car_freq_d     = car_freq_q;
    car_phase_d    = car_phase_q;
    chip_freq_d    = chip_freq_q;
    chip_phase_d   = chip_phase_q;
    prn_d          = prn_q;
    sample_count_d = sample_count_q;
    epoch_count_d  = epoch_count_q;
    epoch_seen_d   = epoch_seen_q;
    s1_valid_d     = accept;
    s1_addr_d      = s1_addr_q;
    s1_neg_d       = s1_neg_q;
    push_d         = s1_valid_q;
    dac_d          = s1_valid_q ? sample : dac_q;
    epoch_d        = 1'b0;

    status_hit  = read && (reg_addr == ADDR_STATUS);
    status_rd_d = status_hit;

    if (accept) begin
      car_phase_d    = car_sum;
      chip_phase_d   = chip_sum;
      sample_count_d = sample_count_q + 32'd1;
      s1_addr_d      = car_phase_q[30] ? ~car_phase_q[29:17] : car_phase_q[29:17];
      s1_neg_d       = car_phase_q[31] ^ chip_bit;
    end

    // Read-clear first so a coincident epoch set overrides it
    if (status_hit && !status_rd_q) epoch_seen_d = 1'b0;

    if (chip_step) begin
      prn_d[13:0] = lfsr_next;
      if (lfsr_next == 14'd1) begin
        epoch_d       = 1'b1;
        epoch_count_d = epoch_count_q + 32'd1;
        epoch_seen_d  = 1'b1;
      end
    end

    if (write) begin
      case (reg_addr)
        ADDR_CTRL:       run_d          = Wdata[0];
        ADDR_CAR_FREQ:   car_freq_d     = Wdata;
        ADDR_CAR_PHASE:  car_phase_d    = Wdata;
        ADDR_CHIP_FREQ:  chip_freq_d    = Wdata;
        ADDR_CHIP_PHASE: chip_phase_d   = Wdata;
        ADDR_PRN:        prn_d          = Wdata;
        ADDR_SAMPLES:    sample_count_d = Wdata;
        ADDR_EPOCHS:     epoch_count_d  = Wdata;
        ADDR_STATUS:     epoch_seen_d   = Wdata[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    Rdata = 32'd0;
    if (read) begin
      case (reg_addr)
        ADDR_CTRL:       Rdata = {31'd0, run_q};
        ADDR_CAR_FREQ:   Rdata = car_freq_q;
        ADDR_CAR_PHASE:  Rdata = car_phase_q;
        ADDR_CHIP_FREQ:  Rdata = chip_freq_q;
        ADDR_CHIP_PHASE: Rdata = chip_phase_q;
        ADDR_PRN:        Rdata = prn_q;
        ADDR_SAMPLES:    Rdata = sample_count_q;
        ADDR_EPOCHS:     Rdata = epoch_count_q;
        ADDR_STATUS:     Rdata = {31'd0, epoch_seen_q};
        default:         Rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q          <= 1'b0;
      car_freq_q     <= 32'd0;
      car_phase_q    <= 32'd0;
      chip_freq_q    <= 32'd0;
      chip_phase_q   <= 32'd0;
      prn_q          <= 32'd0;
      sample_count_q <= 32'd0;
      epoch_count_q  <= 32'd0;
      epoch_seen_q   <= 1'b0;
      status_rd_q    <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_addr_q      <= 13'd0;
      s1_neg_q       <= 1'b0;
      dac_q          <= 16'd0;
      push_q         <= 1'b0;
      epoch_q        <= 1'b0;
    end else begin
      run_q          <= run_d;
      car_freq_q     <= car_freq_d;
      car_phase_q    <= car_phase_d;
      chip_freq_q    <= chip_freq_d;
      chip_phase_q   <= chip_phase_d;
      prn_q          <= prn_d;
      sample_count_q <= sample_count_d;
      epoch_count_q  <= epoch_count_d;
      epoch_seen_q   <= epoch_seen_d;
      status_rd_q    <= status_rd_d;
      s1_valid_q     <= s1_valid_d;
      s1_addr_q      <= s1_addr_d;
      s1_neg_q       <= s1_neg_d;
      dac_q          <= dac_d;
      push_q         <= push_d;
      epoch_q        <= epoch_d;
    end
  end

  assign DAC     = dac_q;
  assign pushDAC = push_q;
  assign epoch   = epoch_q;
endmodule
`default_nettype wire

// File: tb/tb_sst16.sv
`default_nettype none
// ============================================================================
// tb_sst16 : directed self-checking bench for the sst16 transmitter
// Revision: 1.0
// ============================================================================

module tb_sst16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] Wdata = 32'd0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] Rdata;
  logic        tick = 1'b0;
  logic [15:0] DAC;
  logic        pushDAC;
  logic        epoch;

  int tests = 0;
  int failed = 0;

  sst16 dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .Wdata   (Wdata),
    .write   (write),
    .read    (read),
    .Rdata   (Rdata),
    .tick    (tick),
    .DAC     (DAC),
    .pushDAC (pushDAC),
    .epoch   (epoch)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; Wdata = d; write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; read = 1'b1;
    #1 d = Rdata;
    step();
    read = 1'b0;
    step();
  endtask

  logic [31:0] v;
  int pushes, eps, ep_at;

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_dac", {16'd0, DAC}, 32'd0);
    chk("rst_push", {31'd0, pushDAC}, 32'd0);
    chk("rst_epoch", {31'd0, epoch}, 32'd0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      rd(32'h0900 + 32'(i * 4), v);
      chk($sformatf("rst_reg_%0h", 32'h0900 + 32'(i * 4)), v, 32'd0);
    end

    // Ticks while stopped are ignored
    pushes = 0;
    tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pushDAC) pushes++;
    end
    tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (pushDAC) pushes++;
    end
    chk("norun_push", 32'(pushes), 32'd0);
    rd(32'h0918, v);
    chk("norun_samples", v, 32'd0);

    // Carrier quadrants: sine(0)=0, sine(0x1fff)=0x7fff
    wr(32'h0904, 32'h4000_0000);
    wr(32'h0900, 32'h1);
    tick = 1'b1;
    step();
    chk("q_lat_push", {31'd0, pushDAC}, 32'd0);
    step();
    chk("q0_push", {31'd0, pushDAC}, 32'd1);
    chk("q0_dac", {16'd0, DAC}, 32'h0000);
    step();
    chk("q1_dac", {16'd0, DAC}, 32'h7fff);
    step();
    tick = 1'b0;
    chk("q2_dac", {16'd0, DAC}, 32'h0000);
    step();
    chk("q3_dac", {16'd0, DAC}, 32'h8001);
    step();
    chk("q_push_end", {31'd0, pushDAC}, 32'd0);
    rd(32'h0918, v);
    chk("q_samples", v, 32'd4);
    rd(32'h0908, v);
    chk("q_phase", v, 32'd0);

    // LFSR period with hob=3, poly=3, state=1
    wr(32'h0914, 32'h3000_C001);
    wr(32'h090c, 32'h8000_0000);
    wr(32'h0910, 32'h0);
    eps = 0; ep_at = 0;
    for (int i = 1; i <= 29; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (epoch) begin eps++; ep_at = i; end
      if (i == 1) begin rd(32'h0914, v); chk("lfsr_t1", v, 32'h3000_C002); end
      if (i == 7) begin rd(32'h0914, v); chk("lfsr_t7", v, 32'h3000_C003); end
      if (i == 13) begin rd(32'h0914, v); chk("lfsr_t13", v, 32'h3000_C00B); end
    end
    step(); step();
    chk("lfsr_epochs", 32'(eps), 32'd1);
    chk("lfsr_epoch_at", 32'(ep_at), 32'd29);
    rd(32'h0914, v);
    chk("lfsr_state1", v, 32'h3000_C001);
    rd(32'h091c, v);
    chk("lfsr_epoch_count", v, 32'd1);
    rd(32'h0920, v);
    chk("lfsr_status", v, 32'd1);
    rd(32'h0920, v);
    chk("lfsr_status_clr", v, 32'd0);

    // Chip modulation: sine(0x1000)=0x6000
    wr(32'h090c, 32'h0);
    wr(32'h0904, 32'h0);
    wr(32'h0908, 32'h2000_0000);
    tick = 1'b1; step(); tick = 1'b0; step();
    chk("chip0_dac", {16'd0, DAC}, 32'h6000);
    wr(32'h0914, 32'h3000_C008);
    tick = 1'b1; step(); tick = 1'b0; step();
    chk("chip1_push", {31'd0, pushDAC}, 32'd1);
    chk("chip1_dac", {16'd0, DAC}, 32'hA000);

    // Write beats hardware phase update
    wr(32'h0904, 32'h0000_1000);
    addr = 32'h0908; Wdata = 32'h1234_5678; write = 1'b1; tick = 1'b1;
    step();
    write = 1'b0; tick = 1'b0;
    rd(32'h0908, v);
    chk("conflict_phase", v, 32'h1234_5678);

    // Epoch set beats STATUS read-clear
    wr(32'h0914, 32'h3000_C009);
    wr(32'h090c, 32'h8000_0000);
    wr(32'h0910, 32'h0);
    addr = 32'h0920; read = 1'b1; tick = 1'b1;
    #1 v = Rdata;
    chk("conflict_status_pre", v, 32'd0);
    step();
    read = 1'b0; tick = 1'b0;
    chk("conflict_epoch", {31'd0, epoch}, 32'd1);
    step();
    rd(32'h0920, v);
    chk("conflict_status_set", v, 32'd1);
    rd(32'h0920, v);
    chk("conflict_status_clr", v, 32'd0);
    rd(32'h091c, v);
    chk("conflict_epoch_count", v, 32'd2);

    // Mid-stream reset
    tick = 1'b1;
    step(); step(); step();
    chk("mid_push_before", {31'd0, pushDAC}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_push_async", {31'd0, pushDAC}, 32'd0);
    chk("mid_dac_async", {16'd0, DAC}, 32'd0);
    tick = 1'b0;
    step();
    rst = 1'b0;
    pushes = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (pushDAC) pushes++;
    end
    chk("mid_push_after", 32'(pushes), 32'd0);
    for (int i = 0; i < 9; i++) begin
      rd(32'h0900 + 32'(i * 4), v);
      chk($sformatf("mid_reg_%0h", 32'h0900 + 32'(i * 4)), v, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
